// File: rtl/bicubic_rgb_sched_pkg.sv
// Shared types and constants for the RGB bicubic pass scheduler.
package bicubic_rgb_sched_pkg;

  localparam int CHANNEL_WIDTH = 8;
  localparam int NPIX          = 16;
  localparam int PIX_WIDTH     = 3 * CHANNEL_WIDTH;
  localparam int WIN_WIDTH     = NPIX * PIX_WIDTH;
  localparam int POS_WIDTH     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PASS_R = 2'd1,
    ST_PASS_G = 2'd2,
    ST_PASS_B = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } chan_t;

  // Pixel layout is {R, G, B}, R in the top byte.
  function automatic logic [CHANNEL_WIDTH-1:0] chan_of(
    input logic [PIX_WIDTH-1:0] px,
    input chan_t                ch
  );
    logic [CHANNEL_WIDTH-1:0] v;
    case (ch)
      CH_R:    v = px[23:16];
      CH_G:    v = px[15:8];
      default: v = px[7:0];
    endcase
    return v;
  endfunction

endpackage

// File: rtl/bicubic_rgb_sched_chan_buf.sv
// 16-entry channel result buffer: synchronous write, combinational read.
module bicubic_chan_buf
  import bicubic_rgb_sched_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wen,
  input  logic [POS_WIDTH-1:0]     i_waddr,
  input  logic [CHANNEL_WIDTH-1:0] i_wdata,
  input  logic [POS_WIDTH-1:0]     i_raddr,
  output logic [CHANNEL_WIDTH-1:0] o_rdata
);

  logic [CHANNEL_WIDTH-1:0] r_mem [NPIX];

  // Storage: cleared on reset so a discarded window leaves no stale results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPIX; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wen) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bicubic_rgb_sched.sv
// Time-shares one single-channel bicubic core over R, G and B of a 4x4
// window; R and G results are buffered and merged with the live B result.
module bicubic_rgb_sched
  import bicubic_rgb_sched_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     win_valid,
  output logic                     win_ready,
  input  logic [WIN_WIDTH-1:0]     win_data,
  output logic                     sched_req_valid,
  input  logic                     core_req_ready,
  output logic [CHANNEL_WIDTH-1:0] sched_p1,
  output logic [CHANNEL_WIDTH-1:0] sched_p2,
  output logic [CHANNEL_WIDTH-1:0] sched_p3,
  output logic [CHANNEL_WIDTH-1:0] sched_p4,
  output logic [CHANNEL_WIDTH-1:0] sched_p5,
  output logic [CHANNEL_WIDTH-1:0] sched_p6,
  output logic [CHANNEL_WIDTH-1:0] sched_p7,
  output logic [CHANNEL_WIDTH-1:0] sched_p8,
  output logic [CHANNEL_WIDTH-1:0] sched_p9,
  output logic [CHANNEL_WIDTH-1:0] sched_p10,
  output logic [CHANNEL_WIDTH-1:0] sched_p11,
  output logic [CHANNEL_WIDTH-1:0] sched_p12,
  output logic [CHANNEL_WIDTH-1:0] sched_p13,
  output logic [CHANNEL_WIDTH-1:0] sched_p14,
  output logic [CHANNEL_WIDTH-1:0] sched_p15,
  output logic [CHANNEL_WIDTH-1:0] sched_p16,
  input  logic                     core_rsp_valid,
  input  logic [CHANNEL_WIDTH-1:0] core_rsp_data,
  output logic                     sched_rsp_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PIX_WIDTH-1:0]     out_data,
  output logic [POS_WIDTH-1:0]     out_pos,
  output logic                     out_last
);

  state_t                   r_state;
  logic [POS_WIDTH-1:0]     r_pos;
  logic [WIN_WIDTH-1:0]     r_win;
  logic                     r_win_ready;
  logic                     r_req_valid;

  chan_t                    w_ch;
  logic [CHANNEL_WIDTH-1:0] w_sel [NPIX];
  logic                     w_rsp_hs;
  logic                     w_last_pos;
  logic [CHANNEL_WIDTH-1:0] w_rbuf_rd;
  logic [CHANNEL_WIDTH-1:0] w_gbuf_rd;
  logic                     w_unused;

  // The core only advances on a result handshake, so r_pos already tracks
  // its state index; its ready flag carries no extra information here.
  assign w_unused   = core_req_ready;

  assign w_rsp_hs   = core_rsp_valid & sched_rsp_ready;
  assign w_last_pos = (r_pos == POS_WIDTH'(NPIX - 1));

  assign win_ready       = r_win_ready;
  assign sched_req_valid = r_req_valid;

  // Channel presented to the core follows the current pass.
  always_comb begin
    w_ch = CH_R;
    case (r_state)
      ST_PASS_G: w_ch = CH_G;
      ST_PASS_B: w_ch = CH_B;
      default:   w_ch = CH_R;
    endcase
  end

  for (genvar k = 0; k < NPIX; k++) begin : g_sel
    assign w_sel[k] = chan_of(r_win[k*PIX_WIDTH +: PIX_WIDTH], w_ch);
  end

  assign sched_p1  = w_sel[0];
  assign sched_p2  = w_sel[1];
  assign sched_p3  = w_sel[2];
  assign sched_p4  = w_sel[3];
  assign sched_p5  = w_sel[4];
  assign sched_p6  = w_sel[5];
  assign sched_p7  = w_sel[6];
  assign sched_p8  = w_sel[7];
  assign sched_p9  = w_sel[8];
  assign sched_p10 = w_sel[9];
  assign sched_p11 = w_sel[10];
  assign sched_p12 = w_sel[11];
  assign sched_p13 = w_sel[12];
  assign sched_p14 = w_sel[13];
  assign sched_p15 = w_sel[14];
  assign sched_p16 = w_sel[15];

  bicubic_chan_buf u_rbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wen   (w_rsp_hs && (r_state == ST_PASS_R)),
    .i_waddr (r_pos),
    .i_wdata (core_rsp_data),
    .i_raddr (r_pos),
    .o_rdata (w_rbuf_rd)
  );

  bicubic_chan_buf u_gbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wen   (w_rsp_hs && (r_state == ST_PASS_G)),
    .i_waddr (r_pos),
    .i_wdata (core_rsp_data),
    .i_raddr (r_pos),
    .o_rdata (w_gbuf_rd)
  );

  // Pass sequencer: window latch, result counter and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pos       <= '0;
      r_win       <= '0;
      r_win_ready <= 1'b1;
      r_req_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (win_valid) begin
            r_win       <= win_data;
            r_pos       <= '0;
            r_state     <= ST_PASS_R;
            r_win_ready <= 1'b0;
            r_req_valid <= 1'b1;
          end
        end
        ST_PASS_R: begin
          if (w_rsp_hs) begin
            r_pos <= r_pos + 1'b1;
            if (w_last_pos) r_state <= ST_PASS_G;
          end
        end
        ST_PASS_G: begin
          if (w_rsp_hs) begin
            r_pos <= r_pos + 1'b1;
            if (w_last_pos) r_state <= ST_PASS_B;
          end
        end
        ST_PASS_B: begin
          if (w_rsp_hs) begin
            r_pos <= r_pos + 1'b1;
            if (w_last_pos) begin
              r_state     <= ST_IDLE;
              r_win_ready <= 1'b1;
              r_req_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_win_ready <= 1'b1;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

  // Result steering: R/G passes always sink the core; the B pass forwards
  // the live result merged with buffered R/G and obeys downstream backpressure.
  always_comb begin
    sched_rsp_ready = 1'b0;
    out_valid       = 1'b0;
    out_data        = '0;
    out_pos         = '0;
    out_last        = 1'b0;
    case (r_state)
      ST_PASS_R, ST_PASS_G: begin
        sched_rsp_ready = 1'b1;
      end
      ST_PASS_B: begin
        sched_rsp_ready = out_ready;
        out_valid       = core_rsp_valid;
        out_data        = {w_rbuf_rd, w_gbuf_rd, core_rsp_data};
        out_pos         = r_pos;
        out_last        = core_rsp_valid & w_last_pos;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/bicubic_rgb_sched.md
# bicubic_rgb_sched

Scheduler that time-shares one single-channel 16-output bicubic upsample core across the R, G and B channels of a 4x4 RGB source window. It latches a 24-bit-per-pixel window and drives the core through three consecutive 16-output passes (R, then G, then B). It buffers the R and G results and emits 16 packed RGB output pixels in row-major order during the B pass. It sits between the window-fetch stage and the output pixel writer.

## Interface
- CHANNEL_WIDTH, 8, bits per colour channel
- NPIX, 16, pixels per window and output pixels per window (fixed 4x4)
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- win_valid  in  1  upstream window valid
- win_ready  out  1  scheduler accepts a window
- win_data  in  384  pixel k (0..15, row-major) at [24k+23:24k]; R [23:16], G [15:8], B [7:0] within each pixel
- sched_req_valid  out  1  core request valid
- core_req_ready  in  1  core ready (high only in the core's first state)
- sched_p1..sched_p16  out  8 each  selected channel of pixels 0..15
- core_rsp_valid  in  1  core result valid
- core_rsp_data  in  8  core result
- sched_rsp_ready  out  1  scheduler consumes a core result
- out_valid  out  1  RGB output valid
- out_ready  in  1  downstream ready
- out_data  out  24  {R, G, B} of output pixel pos
- out_pos  out  4  output index, row-major (4*row + col)
- out_last  out  1  high on the beat with pos 15

## Operation
- States: IDLE, PASS_R, PASS_G, PASS_B. The 4-bit counter pos counts core result handshakes (rsp_hs = core_rsp_valid & sched_rsp_ready).
- IDLE:
  - win_ready=1, sched_req_valid=0.
  - On win_valid & win_ready: latch win_data into a 384-bit register, pos<=0, go to PASS_R.
- PASS_R and PASS_G:
  - sched_req_valid=1, held for the whole pass.
  - sched_pk = the current pass's channel of latched pixel k-1.
  - sched_rsp_ready=1.
  - Each rsp_hs writes core_rsp_data into rbuf[pos] (PASS_R) or gbuf[pos] (PASS_G), then increments pos.
  - rsp_hs at pos=15 wraps pos to 0 and advances PASS_R to PASS_G, or PASS_G to PASS_B.
- PASS_B:
  - sched_req_valid=1; sched_pk = B channel.
  - out_valid = core_rsp_valid; sched_rsp_ready = out_ready.
  - out_data = {rbuf[pos], gbuf[pos], core_rsp_data}.
  - rsp_hs increments pos. rsp_hs at pos=15 goes to IDLE and wraps pos to 0.
- Outside PASS_B: out_valid=0 and out_last=0.
- Core-state agreement: sched_req_valid and the sched_p* values never change during a pass. The core advances only on rsp_hs, so pos always equals the core's internal state index.
- win_ready is low in every PASS state, so a window arriving mid-pass stalls.
- Core and scheduler share rst_n.
- Reset at any time:
  - State goes to IDLE, pos 0, rbuf/gbuf/window register cleared.
  - win_ready=1; sched_req_valid, sched_rsp_ready, out_valid, out_last = 0; out_data=0, out_pos=0.
  - The partial window is discarded.

## Timing
- Window handshake at cycle T.
- PASS_R occupies cycles T+1..T+16 and PASS_G T+17..T+32; each takes exactly 16 cycles.
- PASS_B occupies T+33..T+48 when out_ready is held at 1; out_ready=0 stalls it with out_data, out_pos and pos held.
- IDLE is at T+49, so the next window can be accepted at T+49. Throughput is 1 window per 49 cycles unstalled.
- No combinational path from out_ready to win_ready.
- out_data's B field is combinational from core_rsp_data; the R and G fields are register reads.

## Structure
- The shared package holds:
  - CHANNEL_WIDTH, NPIX, window width (384)
  - state encodings (2-bit)
  - channel-select enum {CH_R, CH_G, CH_B}
- Sub-module bicubic_chan_buf: a 16x8 register file with synchronous write (wen, waddr) and async-reset clear. It is instantiated twice (rbuf, gbuf), and both are read combinationally at pos.

## Test plan
- Reset: with rst_n low, win_ready=1; sched_req_valid, sched_rsp_ready, out_valid and out_last are 0; out_data=0x000000.
- Uniform window: all pixels 0x4080C0, out_ready=1, accepted at T.
  - Required: 16 beats at T+33..T+48, each out_data=0x4080C0.
  - out_pos runs 0..15; out_last is set only at T+48; win_ready returns to 1 at T+49.
- Position mapping: only pixel 5 is nonzero (0x11AA33), all others 0.
  - Required: the pos-0 beat is 0x11AA33, since the core's pos-0 weights select pixel 5 exactly.
- Backpressure: out_ready toggles 1,0,0,1,... during PASS_B.
  - Required: a beat completes only on cycles with out_ready=1, and out_data/out_pos stay stable while stalled.
  - All 16 beats are delivered in order, none dropped or duplicated.
- Back-to-back: win_valid held high with windows A then B.
  - Required: win_ready stays 0 from T+1 to T+48; B is accepted at T+49; B's outputs are correct and unaffected by A's buffer contents.
- Reset mid-pass: pulse rst_n low during PASS_G at pos=7, then send a new uniform 0x102030 window.
  - Required: 48-cycle sequence restarts from pos 0; all 16 outputs 0x102030.
